rr_arbiter_2to1: RTL
====================

# rr_arbiter_2to1

Round-robin arbiter that lets two blocking-input producers share one blocking-output consumer. Each transfer reads one 32-bit word from whichever producer is granted and forwards it unchanged to the shared output. A one-cycle master-output pulse reports which producer supplied the word. The block sits between producer modules and a shared sink, using the same sync/notify port triples as the surrounding generated modules.

## Interface
- FIRST_PRIO, default 0: requester that wins a simultaneous request after reset (0 = a, 1 = b).
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_in  input  32 (integer)  data word from requester a.
- a_in_sync  input  1  requester a offers a word this cycle.
- a_in_notify  output  1  arbiter ready to accept from a.
- b_in  input  32 (integer)  data word from requester b.
- b_in_sync  input  1  requester b offers a word this cycle.
- b_in_notify  output  1  arbiter ready to accept from b.
- out  output  32 (integer)  forwarded word.
- out_sync  input  1  consumer accepts the word this cycle.
- out_notify  output  1  word on out is valid.
- src_out  output  1  source of the current word (0 = a, 1 = b).
- src_out_notify  output  1  single-cycle pulse, src_out is valid.

## Operation
- Handshakes:
  - An input transfer occurs at a clock edge where x_in_sync && x_in_notify. x_in is sampled at that edge.
  - An output transfer occurs at an edge where out_sync && out_notify.
  - A sync with its notify low is ignored.
- States (enum): ST_READ, ST_WRITE. The block also holds a 1-bit priority register prio.
- ST_READ:
  - a_in_notify = b_in_notify = 1, out_notify = 0.
  - If only one sync is high, that requester is granted.
  - If both are high, requester prio is granted.
  - If neither is high, stay in ST_READ.
  - On a grant: capture the word into out and the source into src_out, set prio to the non-granted requester, go to ST_WRITE.
- ST_WRITE:
  - a_in_notify = b_in_notify = 0, out_notify = 1.
  - out and src_out stay stable until the transfer completes.
  - On out_sync: go to ST_READ.
  - Otherwise stay in ST_WRITE indefinitely; there is no timeout.
- src_out_notify is high only in the first cycle of each ST_WRITE visit.
- Data passes through bit-exact. There is no arithmetic and no sign handling.
- prio changes only on a grant. Idle cycles do not rotate it.

## Timing
- Reset values (applied at a posedge with rst = 1):
  - state = ST_READ, a_in_notify = 1, b_in_notify = 1.
  - out_notify = 0, src_out_notify = 0, out = 0, src_out = 0.
  - prio = FIRST_PRIO.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Latency: capture at edge k gives out_notify = 1 and src_out_notify = 1 from cycle k+1.
- Fastest cycle: if out_sync is high at edge k+1, both in_notify signals return to 1 in cycle k+2.
  - Peak throughput is therefore one word per 2 cycles.
- Simultaneous requests: the loser's sync is not consumed. The loser must keep x_in_sync and data asserted and is granted on the next ST_READ edge.
  - Fairness: with both requesting continuously, grants strictly alternate.
- out_sync while in ST_READ has no effect.
- Reset mid-transfer: any held word is discarded without being delivered, and the block restarts in ST_READ.
- rst has priority over every handshake at the same edge.

## Structure
- Package rr_arbiter_2to1_types holds:
  - the state enum (ST_READ, ST_WRITE);
  - source constants SRC_A = 1'b0 and SRC_B = 1'b1.
- Single flat module with one always_ff process containing a synchronous `if (rst)` branch. No sub-module is needed.
- The grant decision may be a small combinational function in the package.

## Test plan
- Reset then idle: all outputs take their reset values; a_in_notify = b_in_notify = 1, and both stay 1 for 10 idle cycles.
- Single request: a_in = 32'h0000_1234 with a_in_sync = 1 and out_sync held at 1.
  - Next cycle: out = 32'h1234, out_notify = 1, src_out = 0, src_out_notify = 1.
  - Following cycle: in_notify signals back to 1.
- Simultaneous requests after reset with FIRST_PRIO = 0: a = 5, b = 9, both held.
  - Words delivered in the order 5, 9, 5, 9.
  - src_out sequence is 0, 1, 0, 1.
- Backpressure: out_sync = 0 for 6 cycles after a grant of b = -1.
  - out stays 32'hFFFF_FFFF, out_notify stays 1, and src_out_notify is high only in the first cycle.
  - Both in_notify signals stay 0 until out_sync = 1.
- Reset during ST_WRITE: the word is never delivered; the cycle after the rst edge shows the reset values.
  - A subsequent simultaneous request is granted per FIRST_PRIO.
- Priority retention: grant b, then 5 idle cycles, then a and b request together → a wins.

Source files
------------

// File: rtl/rr_arbiter_2to1_pkg.sv
// Shared types and grant-decision helper for the two-input round-robin arbiter.
// Both the arbiter and anything that decodes its source field import this package.
package rr_arbiter_2to1_types;

    typedef enum logic {
        ST_READ  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned DATA_W = 32;

    // A lone requester always wins; on a tie the requester named by prio wins.
    function automatic logic pick_src(
        input logic a_req,
        input logic b_req,
        input logic prio
    );
        logic src;
        src = SRC_A;
        if (a_req && b_req) begin
            src = prio;
        end else if (b_req) begin
            src = SRC_B;
        end else begin
            src = SRC_A;
        end
        return src;
    endfunction

endpackage

// File: rtl/rr_arbiter_2to1.sv
// Two-producer, one-consumer round-robin arbiter with a one-word holding register.
// All outputs are registered. A word is accepted in ST_READ and presented in ST_WRITE.
module rr_arbiter_2to1
    import rr_arbiter_2to1_types::*;
#(
    parameter logic FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_in_sync,
    output logic              a_in_notify,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_in_sync,
    output logic              b_in_notify,
    output logic [DATA_W-1:0] out,
    input  logic              out_sync,
    output logic              out_notify,
    output logic              src_out,
    output logic              src_out_notify
);

    state_e            state_q;
    logic              prio_q;
    logic              a_notify_q;
    logic              b_notify_q;
    logic              out_notify_q;
    logic              src_notify_q;
    logic [DATA_W-1:0] out_q;
    logic              src_q;

    // Qualified requests: a sync counts only while its notify is high.
    logic a_req;
    logic b_req;
    logic grant_valid;
    logic grant_src;
    logic out_xfer;

    always_comb begin
        a_req       = a_in_sync && a_notify_q;
        b_req       = b_in_sync && b_notify_q;
        grant_valid = a_req || b_req;
        grant_src   = pick_src(a_req, b_req, prio_q);
        out_xfer    = out_sync && out_notify_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_READ;
            prio_q       <= FIRST_PRIO;
            a_notify_q   <= 1'b1;
            b_notify_q   <= 1'b1;
            out_notify_q <= 1'b0;
            src_notify_q <= 1'b0;
            out_q        <= '0;
            src_q        <= SRC_A;
        end else begin
            src_notify_q <= 1'b0;
            case (state_q)
                ST_READ: begin
                    if (grant_valid) begin
                        out_q        <= (grant_src == SRC_B) ? b_in : a_in;
                        src_q        <= grant_src;
                        prio_q       <= ~grant_src;
                        state_q      <= ST_WRITE;
                        a_notify_q   <= 1'b0;
                        b_notify_q   <= 1'b0;
                        out_notify_q <= 1'b1;
                        src_notify_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (out_xfer) begin
                        state_q      <= ST_READ;
                        a_notify_q   <= 1'b1;
                        b_notify_q   <= 1'b1;
                        out_notify_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_READ;
                    a_notify_q   <= 1'b1;
                    b_notify_q   <= 1'b1;
                    out_notify_q <= 1'b0;
                end
            endcase
        end
    end

    assign a_in_notify    = a_notify_q;
    assign b_in_notify    = b_notify_q;
    assign out            = out_q;
    assign out_notify     = out_notify_q;
    assign src_out        = src_q;
    assign src_out_notify = src_notify_q;

endmodule
